// File: rtl/axis_test_ram_writer.sv
// Captures one framed AXI-stream burst into an internal RAM and exposes a
// fully pipelined readback port with configurable latency.
module axis_test_ram_writer #(
    parameter int DEPTH        = 33,
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           us_data,
    input  logic                       us_valid,
    input  logic                       us_last,
    output logic                       us_next_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_last_early,
    output logic                       err_last_missing,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH-1);
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic                   w_xfer;
    logic                   w_arm;
    logic                   w_finalWord;
    logic [CW-1:0]          r_wordCount;
    logic                   r_errEarly;
    logic                   r_errMissing;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [WIDTH-1:0]       r_pipeData [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipeVld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Ready is a pure function of state, so the frame stops the cycle after its final transfer.
    always_comb begin
        w_stateNext  = r_state;
        us_next_data = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_xfer       = 1'b0;
        w_arm        = 1'b0;
        w_finalWord  = (r_wordCount == LAST_IDX);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_arm       = 1'b1;
                    w_stateNext = RECEIVE;
                end
            end
            RECEIVE: begin
                us_next_data = 1'b1;
                busy         = 1'b1;
                w_xfer       = us_valid;
                if (us_valid && (w_finalWord || us_last)) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_arm       = 1'b1;
                    w_stateNext = RECEIVE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wordCount  <= '0;
            r_errEarly   <= 1'b0;
            r_errMissing <= 1'b0;
        end else if (w_arm) begin
            r_wordCount  <= '0;
            r_errEarly   <= 1'b0;
            r_errMissing <= 1'b0;
        end else if (w_xfer) begin
            r_wordCount <= r_wordCount + 1'b1;
            if (w_finalWord) begin
                r_errMissing <= !us_last;
            end else if (us_last) begin
                r_errEarly <= 1'b1;
            end
        end
    end

    // The RAM deliberately has no reset so an abandoned frame leaves its words in place.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_wordCount[AW-1:0]] <= us_data;
        end
    end

    // Stage 0 samples the RAM on the request edge; each further stage adds one cycle.
    // Data stages only load behind a valid, so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipeVld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipeData[k] <= '0;
            end
        end else begin
            r_pipeVld[0] <= rd_en;
            if (rd_en) begin
                r_pipeData[0] <= ({1'b0, rd_addr} < DEPTH_EXT) ? r_mem[rd_addr] : '0;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipeVld[k] <= r_pipeVld[k-1];
                if (r_pipeVld[k-1]) begin
                    r_pipeData[k] <= r_pipeData[k-1];
                end
            end
        end
    end

    assign word_count       = r_wordCount;
    assign err_last_early   = r_errEarly;
    assign err_last_missing = r_errMissing;
    assign rd_valid         = r_pipeVld[READ_LATENCY-1];
    assign rd_data          = r_pipeData[READ_LATENCY-1];

endmodule

// File: doc/axis_test_ram_writer.md
AXIS_TEST_RAM_WRITER -- requirements
Module: axis_test_ram_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 33: number of words in one stream frame and RAM entries.
REQ-002 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-003 SHALL have parameter READ_LATENCY, default 2: readback latency in cycles, legal range 1..4.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1: one-cycle pulse that arms reception of one frame.
REQ-007 SHALL have port us_data  input  WIDTH: upstream stream data.
REQ-008 SHALL have port us_valid  input  1: upstream data valid.
REQ-009 SHALL have port us_last  input  1: upstream marks final word of frame.
REQ-010 SHALL have port us_next_data  output  1: ready to upstream; a transfer occurs on a clk edge where us_valid and us_next_data are both 1.
REQ-011 SHALL have port busy  output  1: frame reception in progress.
REQ-012 SHALL have port done  output  1: frame reception finished.
REQ-013 SHALL have port err_last_early  output  1: us_last seen before word DEPTH-1.
REQ-014 SHALL have port err_last_missing  output  1: word DEPTH-1 accepted without us_last.
REQ-015 SHALL have port word_count  output  $clog2(DEPTH+1): words accepted in current/last frame.
REQ-016 SHALL have port rd_en  input  1: readback request.
REQ-017 SHALL have port rd_addr  input  $clog2(DEPTH): readback address.
REQ-018 SHALL have port rd_data  output  WIDTH: readback data.
REQ-019 SHALL have port rd_valid  output  1: rd_data valid this cycle.

Function
REQ-020 SHALL implement states IDLE, RECEIVE, DONE.
REQ-021 IDLE: us_next_data=0, busy=0, done=0; start=1 -> RECEIVE next cycle, with word_count=0 and both error flags cleared.
REQ-022 RECEIVE: us_next_data=1 and busy=1 combinationally from state; us_valid=0 cycles hold state unchanged.
REQ-023 On each transfer SHALL write us_data to RAM[word_count] and increment word_count by 1 on the same edge.
REQ-024 Transfer with word_count=DEPTH-1: us_last=1 -> DONE, no error; us_last=0 -> DONE with err_last_missing=1.
REQ-025 Transfer with word_count<DEPTH-1 and us_last=1 -> word still written, word_count incremented, DONE with err_last_early=1.
REQ-026 us_next_data SHALL be 0 from the cycle after the final transfer; no word beyond DEPTH is ever written.
REQ-027 DONE: done=1, busy=0, us_next_data=0; word_count and error flags held; start=1 -> RECEIVE with same clearing as REQ-021.
REQ-028 start while in RECEIVE SHALL be ignored (no restart, no count reset).
REQ-029 start and a transfer SHALL never both be acted on in the same cycle outside RECEIVE (ready is 0 in IDLE/DONE).
REQ-030 Readback: rd_en=1 at edge N SHALL yield rd_data=RAM[rd_addr] with rd_valid=1 exactly at edge N+READ_LATENCY; one request per cycle, fully pipelined, legal in any state.
REQ-031 Read and write to same address on same edge SHALL return the old (pre-write) data.
REQ-032 rd_addr >= DEPTH SHALL return rd_data=0 with rd_valid=1 at normal latency.
REQ-033 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-034 rst=1 SHALL asynchronously force state IDLE, us_next_data=0, busy=0, done=0, both error flags 0, word_count=0, rd_valid=0 and clear the read pipeline, rd_data=0.
REQ-035 RAM contents SHALL NOT be reset; rst mid-RECEIVE abandons the frame, words already written remain.
REQ-036 After rst deasserts, the block SHALL stay IDLE until start.

Verification
REQ-037 Nominal: start, 33 words 0x3F800000+i, us_valid=1 every cycle, us_last on i=32 -> done=1, word_count=33, no errors, readback of addr 0..32 matches, rd_valid at +2 cycles.
REQ-038 Throttled: us_valid 1-of-3 cycles, same 33 words -> identical RAM contents and word_count=33; busy=1 throughout.
REQ-039 Early last: us_last on word 10 -> err_last_early=1, word_count=11, done=1, us_next_data=0 thereafter, RAM[11..32] unchanged.
REQ-040 Missing last: 33 words, us_last never set -> err_last_missing=1, word_count=33; a 34th valid word is not accepted.
REQ-041 Back-to-back frames: second start in DONE with new data 0xC0000000+i -> flags cleared, RAM overwritten, readback matches second frame; start during RECEIVE ignored.
REQ-042 Reset mid-frame: rst asserted after word 5 -> outputs per REQ-034 immediately (before next clk edge), RAM[0..5] retained, new start receives full frame correctly.
